fifo_fwft: RTL and testbench
============================

Name: fifo_fwft

Overview:
Parametrised successor to the single-EBR byte FIFO, sitting between producers and consumers across the design (UART, bus bridges).
- Width and depth are generic; the RAM may span several EBRs.
- Allows back-to-back push and back-to-back pop.
- First-word-fall-through: when `empty` is low, `data_out` already holds the head entry.
- Adds occupancy count, almost-full/almost-empty flags, synchronous flush, and separate sticky overflow/underflow flags that replace the single `error` output.

Parameters:
- WIDTH, 8, bits per entry (1..32).
- DEPTH, 512, number of entries; must be a power of two, >= 4.
- AFULL_LVL, DEPTH-4, `almost_full` asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 4, `almost_empty` asserts when count <= AEMPTY_LVL.
- Derived: ADDRW = $clog2(DEPTH); CNTW = $clog2(DEPTH+1).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents; takes priority over push/pop.
- push_back  in  1  write request.
- data_in  in  WIDTH  write data, sampled with push_back.
- pop_front  in  1  consume head entry.
- data_out  out  WIDTH  head entry; valid whenever empty=0.
- empty  out  1  no entry visible at data_out.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AEMPTY_LVL.
- almost_full  out  1  count >= AFULL_LVL.
- count  out  CNTW  entries held, including the output-register entry.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (async assert, sync release): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0, output-valid flag=0.
- Flush: same values as reset, except overflow/underflow are kept. Push and pop in the same cycle are ignored.
- Accepted push: `push_back && !full`. Writes RAM[wr_ptr] and increments wr_ptr, which wraps at DEPTH.
- Push when full: dropped, overflow<=1. This holds even with a simultaneous pop; the slot frees on the next cycle.
- Accepted pop: `pop_front && !empty`. Pop while empty: ignored, underflow<=1.
- Count update: +1 on accepted push only, -1 on accepted pop only, unchanged when both are accepted. Flags derive combinationally from count, except empty.
- Read path: registered-read RAM feeding a one-entry output register (out_valid). Prefetch state machine:
  - IDLE (out_valid=0, RAM not empty): issue read at rd_ptr, increment rd_ptr, go to FETCH.
  - FETCH: next cycle load RAM data into output register, out_valid=1, go to VALID.
  - VALID + accepted pop + RAM non-empty: issue next read and go to FETCH, with out_valid held so head is continuous. The read data replaces data_out on the following edge, giving a 1-cycle bubble.
    - Bubble rule: during that cycle empty=1 is not allowed. The design keeps a 2-entry skid (output reg plus one prefetch reg) so consecutive pops each cycle see valid data.
  - VALID + pop + nothing left: go to IDLE, out_valid=0.
- empty = !out_valid.
- Latency:
  - Push into an empty FIFO at edge N → empty=0 and data_out valid after edge N+2.
  - Pop at edge N → next head visible after edge N (same-cycle advance) when at least 2 entries were held.
- Same-address hazard: a read of the address written in the same cycle never occurs, because prefetch only reads entries written on a prior edge.
- Throughput: sustained 1 push and 1 pop per cycle.
- clr_err has lower priority than a new error in the same cycle: the flag stays 1.

Decomposition:
- Package fifo_pkg: `fifo_state_t` enum {IDLE, FETCH, VALID} and helper function clog2_p1 for CNTW.
- Sub-module dp_bram_gen #(WIDTH, DEPTH): generic simple dual-port RAM, one write port, registered read port with read-enable.
- The FIFO top holds pointers, count, skid registers, state machine and flags.

Test Plan:
- Reset then push 0xA5 at edge 1 → empty falls after edge 3; data_out=0xA5, count=1; pop → empty=1, count=0.
- Push 0..DEPTH-1 on consecutive cycles → full=1 at count=DEPTH; almost_full first seen at count=DEPTH-4; extra push of 0xFF → overflow=1, count stays DEPTH; pop all → sequence 0..DEPTH-1 in order.
- Full FIFO, push and pop same cycle → push dropped, overflow=1, count=DEPTH-1; next cycle push accepted → count=DEPTH.
- Steady state, push and pop every cycle for 3×DEPTH cycles → count constant, no empty glitch, output stream equals input stream; pointers wrap correctly.
- Pop on empty → underflow=1, count=0; clr_err → underflow=0; flush with 10 entries → count=0, empty=1, overflow unchanged.
- Assert rst mid-burst, asynchronously between edges → outputs take reset values immediately; first push after release returns correct data.

Source files
------------

// File: rtl/fifo_fwft_pkg.sv
// Shared types and helpers for the first-word-fall-through FIFO.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_pkg;

    // Output-register status: empty and idle, read in flight toward an
    // empty output register, or head entry valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fifo_state_t;

    // Bits needed to hold 0..n inclusive (occupancy counter width).
    function automatic int clog2_p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fifo_fwft_if.sv
// Producer/consumer bundle for fifo_fwft: push side, pop side, control and status.
// Latency: n/a (wires only).
// Backpressure: full/empty plus sticky overflow/underflow reported to the master.
interface fifo_fwft_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512
);
    localparam int CNTW = clog2_p1(DEPTH);

    logic             flush;
    logic             push_back;
    logic [WIDTH-1:0] data_in;
    logic             pop_front;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CNTW-1:0]  count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, push_back, data_in, pop_front, clr_err,
        input  data_out, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

    modport slave (
        input  flush, push_back, data_in, pop_front, clr_err,
        output data_out, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

endinterface

// File: rtl/fifo_fwft_dp_bram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Latency: read data appears one edge after i_re.
// Backpressure: none; caller owns address validity.
module dp_bram_gen #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512,
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [ADDRW-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdat,
    input  logic             i_re,
    input  logic [ADDRW-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdat
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdat;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdat;
    end

    // Registered read port; holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (i_re) r_rdat <= r_mem[i_raddr];
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/fifo_fwft.sv
// FWFT FIFO: RAM-backed queue with prefetched head register plus one skid entry.
// Latency: push into empty -> head visible after 2 edges; pop advances head on the same edge.
// Backpressure: push while full dropped (sticky overflow), pop while empty ignored (sticky underflow).
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 512,
    parameter int AFULL_LVL  = DEPTH - 4,
    parameter int AEMPTY_LVL = 4
) (
    input  logic       clk,
    input  logic       rst,
    fifo_fwft_if.slave bus
);
    localparam int ADDRW = $clog2(DEPTH);
    localparam int CNTW  = clog2_p1(DEPTH);
    localparam logic [ADDRW:0]  PTR_ONE = (ADDRW+1)'(1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    fifo_state_t      r_state, w_state_nxt;
    logic [ADDRW:0]   r_wr_ptr, r_rd_ptr;   // extra MSB distinguishes full RAM from empty
    logic [CNTW-1:0]  r_count;
    logic [WIDTH-1:0] r_out_dat, r_skid_dat;
    logic             r_skid_vld, r_rd_inflight;
    logic             r_overflow, r_underflow;

    logic             w_out_vld, w_full, w_push_acc, w_pop_acc, w_rd_issue, w_out_take;
    logic [ADDRW:0]   w_ram_cnt;
    logic [1:0]       w_stage_after;
    logic [WIDTH-1:0] w_ram_rdat;

    assign w_out_vld  = (r_state == VALID);
    assign w_full     = (r_count == CNTW'(DEPTH));
    assign w_push_acc = bus.push_back && !w_full && !bus.flush;
    assign w_pop_acc  = bus.pop_front && w_out_vld && !bus.flush;
    assign w_out_take = w_pop_acc || !w_out_vld;

    // Entries still sitting in RAM (written on an earlier edge, not yet read).
    assign w_ram_cnt = r_wr_ptr - r_rd_ptr;

    // Entries in output reg + skid + in-flight read once this cycle's pop leaves.
    // Capping this at 2 means an arriving read always has a free slot.
    assign w_stage_after = {1'b0, w_out_vld} + {1'b0, r_skid_vld}
                         + {1'b0, r_rd_inflight} - {1'b0, w_pop_acc};
    assign w_rd_issue = !bus.flush && (w_ram_cnt != '0) && (w_stage_after < 2'd2);

    dp_bram_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_we    (w_push_acc),
        .i_waddr (r_wr_ptr[ADDRW-1:0]),
        .i_wdat  (bus.data_in),
        .i_re    (w_rd_issue),
        .i_raddr (r_rd_ptr[ADDRW-1:0]),
        .o_rdat  (w_ram_rdat)
    );

    // Output-register state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: FETCH always lands next edge; VALID drops only when nothing is queued behind.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_rd_issue) w_state_nxt = FETCH;
                FETCH:   w_state_nxt = VALID;
                VALID:   if (w_pop_acc && !r_skid_vld && !r_rd_inflight)
                             w_state_nxt = w_rd_issue ? FETCH : IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Head/skid datapath: refill the head from skid first, then from the arriving read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_dat     <= '0;
            r_skid_dat    <= '0;
            r_skid_vld    <= 1'b0;
            r_rd_inflight <= 1'b0;
        end else if (bus.flush) begin
            r_out_dat     <= '0;
            r_skid_dat    <= '0;
            r_skid_vld    <= 1'b0;
            r_rd_inflight <= 1'b0;
        end else begin
            r_rd_inflight <= w_rd_issue;
            if (w_out_take) begin
                if (r_skid_vld) begin
                    r_out_dat  <= r_skid_dat;
                    r_skid_dat <= w_ram_rdat;
                    r_skid_vld <= r_rd_inflight;
                end else if (r_rd_inflight) begin
                    r_out_dat <= w_ram_rdat;
                end
            end else if (r_rd_inflight) begin
                r_skid_dat <= w_ram_rdat;
                r_skid_vld <= 1'b1;
            end
        end
    end

    // Pointers and occupancy count (count covers RAM, in-flight, skid and head).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_issue) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push_acc && !w_pop_acc)      r_count <= r_count + CNT_ONE;
            else if (w_pop_acc && !w_push_acc) r_count <= r_count - CNT_ONE;
        end
    end

    // Sticky error flags: a new error wins over clr_err; flush leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (!bus.flush && bus.push_back && w_full)     r_overflow <= 1'b1;
            else if (bus.clr_err)                          r_overflow <= 1'b0;
            if (!bus.flush && bus.pop_front && !w_out_vld) r_underflow <= 1'b1;
            else if (bus.clr_err)                          r_underflow <= 1'b0;
        end
    end

    assign bus.data_out     = r_out_dat;
    assign bus.empty        = !w_out_vld;
    assign bus.full         = w_full;
    assign bus.almost_empty = (r_count <= CNTW'(AEMPTY_LVL));
    assign bus.almost_full  = (r_count >= CNTW'(AFULL_LVL));
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_fwft.sv
// Self-checking bench for fifo_fwft: directed scenarios then random traffic against a queue model.
// Latency: model says an entry is visible at the head two edges after its push.
// Backpressure: model drops pushes at DEPTH entries and rejects pops when nothing is visible.
module tb_fifo_fwft;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_fwft_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [WIDTH-1:0] d;
        int               t;   // edge index at which the push was taken
    } ent_t;

    ent_t q[$];
    int   e = 0;        // edges stepped through the model
    bit   m_ovf = 1'b0;
    bit   m_unf = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Head is visible once two edges have passed since it was pushed.
    function automatic bit model_vis();
        if (q.size() == 0) return 1'b0;
        return e >= q[0].t + 2;
    endfunction

    task automatic check_all();
        int sz;
        bit vis;
        sz  = q.size();
        vis = model_vis();
        chk("count", 32'(bus.count), sz);
        chk("empty", 32'(bus.empty), 32'(!vis));
        chk("full", 32'(bus.full), 32'(sz == DEPTH));
        chk("almost_full", 32'(bus.almost_full), 32'(sz >= DEPTH - 4));
        chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= 4));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_unf));
        if (vis) chk("data_out", 32'(bus.data_out), 32'(q[0].d));
    endtask

    task automatic step(input bit push, input logic [WIDTH-1:0] din, input bit pop,
                        input bit fl, input bit clr);
        bit vis, was_full, new_o, new_u;
        bus.push_back = push;
        bus.data_in   = din;
        bus.pop_front = pop;
        bus.flush     = fl;
        bus.clr_err   = clr;
        @(posedge clk);
        new_o = 1'b0;
        new_u = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            vis      = model_vis();
            was_full = (q.size() == DEPTH);
            new_o    = push && was_full;
            new_u    = pop && !vis;
            if (pop && vis) void'(q.pop_front());
            if (push && !was_full) q.push_back('{din, e + 1});
        end
        if (new_o) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (new_u) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
        e++;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_model();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic quiet_inputs();
        bus.push_back = 1'b0;
        bus.data_in   = '0;
        bus.pop_front = 1'b0;
        bus.flush     = 1'b0;
        bus.clr_err   = 1'b0;
    endtask

    initial begin
        int pp;
        quiet_inputs();

        // Power-on reset values.
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        check_all();
        chk("rst_data_out", 32'(bus.data_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single entry: visible two edges after the push, then pop back to empty.
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("single_head", 32'(bus.data_out), 32'hA5);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Fill to DEPTH, overflow attempt, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Full with simultaneous push and pop: push dropped, slot usable next edge.
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Steady state: one push and one pop per edge at constant occupancy, pointers wrap.
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, WIDTH'($urandom), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Pop on empty, error clear, then flush with 10 entries and overflow set.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i * 3), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 10; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Random traffic: filling bias, then draining bias, rare flush and error clears.
        for (int i = 0; i < 600; i++) begin
            pp = (i < 300) ? 65 : 35;
            step($urandom_range(0, 99) < pp, WIDTH'($urandom),
                 $urandom_range(0, 99) < (100 - pp),
                 $urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset between edges in the middle of a burst.
        for (int i = 0; i < 6; i++) step(1'b1, WIDTH'(8'hC0 + i), i > 3, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        clear_model();
        check_all();
        chk("arst_data_out", 32'(bus.data_out), 32'h0);
        quiet_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("post_rst_head", 32'(bus.data_out), 32'h3C);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
